load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side initiator for the processor datapath's 128 × 32-bit data memory. It accepts one load or store per request from the execute stage, sequences `MemRead`/`MemWrite` toward the data memory, and returns load data. Supported access sizes are byte, halfword and word. Sub-word stores are done as a read-modify-write. `MemWrite` is generated as a clean one-cycle pulse with address and data stable around it, because the memory writes on the rising edge of `MemWrite`.

## Interface
No parameters.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid && req_ready` on a clock edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low-order bits.
- `resp_valid` out 1: one-cycle pulse at completion of every accepted request.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; the request was rejected and caused no memory access.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write strobe; the memory writes on its rising edge.
- `addr` out 32: memory byte address, word-aligned (bits [1:0] forced to 0).
- `write_data` out 32: memory write data.
- `read_data` in 32: memory read data, combinational from `addr` while `MemRead` is high.

## Operation
- Request fields are latched on acceptance; inputs are ignored until the next IDLE.
- **Error check** at acceptance. Any of the following is an error, and the FSM goes straight to DONE with `resp_err`=1:
  - `req_size`=11;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - out-of-range address (see Configuration).
- **States:** IDLE, RD, WSETUP, WPULSE, WHOLD, DONE.
- **Transitions:**
  - Load: IDLE → RD → DONE.
  - Word store: IDLE → WSETUP → WPULSE → WHOLD → DONE.
  - Sub-word store: IDLE → RD → WSETUP → WPULSE → WHOLD → DONE.
  - DONE → IDLE always.
- **RD:**
  - `MemRead`=1 and `addr`={`req_addr`[31:2],2'b00}.
  - `read_data` is captured at the end of RD.
- **Load extract (little-endian):**
  - Byte lane k=`addr[1:0]`: bits [8k+7:8k].
  - Halfword lane = `addr[1]`: bits [16h+15:16h].
  - The result is extended per `req_unsigned`.
- **Store merge:**
  - Byte: the captured word with lane k replaced by `req_wdata[7:0]`.
  - Halfword: lane h replaced by `req_wdata[15:0]`.
  - Word: `req_wdata` unchanged.
- **Write sequence:**
  - WSETUP: `addr` and `write_data` are driven, `MemWrite`=0.
  - WPULSE: `MemWrite`=1.
  - WHOLD: `MemWrite`=0, `addr`/`write_data` held.
- `MemRead` and `MemWrite` are never high in the same cycle.
- All memory-side outputs are registered.

## Timing
- **Reset values:**
  - `MemRead`, `MemWrite`, `addr`, `write_data`, `resp_valid`, `resp_rdata` and `resp_err` are all 0.
  - The FSM is in IDLE, so `req_ready`=1.
- **Latency** (accept edge to `resp_valid` high):
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 4 cycles.
  - Sub-word store: 5 cycles.
- `resp_valid` is high for exactly 1 cycle, in DONE. `req_ready` goes high the cycle after.
- Throughput is one request per (latency + 1) cycles; there is no overlap between requests.
- `MemWrite` is high for exactly one cycle per store.
- `addr`/`write_data` are stable from the start of WSETUP through the end of WHOLD.
- **Reset mid-operation:**
  - All outputs go to reset values immediately (asynchronously).
  - The transaction is abandoned with no `resp_valid`.
  - If reset hits in WSETUP, no write occurs.
  - If reset hits in WPULSE or WHOLD, the write already happened at the pulse's rising edge.

## Configuration
- **`LSU_RANGE_CHECK_EN` defined:**
  - A request with `req_addr[31:9]`≠0 (outside the 512-byte memory) is an error.
  - It returns `resp_err`=1 with 1-cycle latency and makes no memory access.
- **Not defined:** no range check. Upper address bits pass through to `addr`, and the memory aliases them via bits [8:2].

## Test plan
1. Word store 0xDEADBEEF to 0x10, then word load 0x10 → `resp_rdata`=0xDEADBEEF.
   - Store `resp_valid` 4 cycles after accept; load 2 cycles after.
   - `MemWrite` high exactly 1 cycle, with `addr`=0x10 stable WSETUP–WHOLD.
2. Word 0x11223344 at 0x20, then byte store 0xA5 to 0x23 → word at 0x20 reads 0xA5223344.
   - Byte load 0x23 signed → 0xFFFFFFA5; unsigned → 0x000000A5.
   - Byte store `resp_valid` 5 cycles after accept.
3. Word 0x80011234 at 0x30 → halfword load 0x32 signed gives 0xFFFF8001; 0x30 unsigned gives 0x00001234.
4. Misaligned accesses, word load 0x06 and halfword store 0x05 → `resp_err`=1 one cycle after accept, `resp_rdata`=0, `MemRead`/`MemWrite` never asserted, memory unchanged.
5. `rst_n` driven low during WPULSE of a store → `MemWrite`, `addr` and `write_data` go to 0 without waiting for a clock edge, no `resp_valid`, `req_ready`=1 after release.
6. Word load at 0x200, checked in both builds:
   - With `LSU_RANGE_CHECK_EN`: `resp_err`=1, no `MemRead`.
   - Without it: returns the contents of word 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-side initiator for a 128 x 32-bit data memory. Accepts one load or
//   store per request, sequences MemRead/MemWrite, and returns load data.
//   Sub-word stores are performed as read-modify-write. MemWrite is a clean
//   one-cycle pulse with addr/write_data held for a cycle on either side,
//   because the memory writes on the rising edge of MemWrite.
//
//   Build option: define LSU_RANGE_CHECK_EN to reject addresses outside the
//   512-byte memory (req_addr[31:9] != 0). Without it the upper bits pass
//   through and the memory aliases them.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write/req_size     store flag, size (00 byte, 01 half, 10 word, 11 illegal)
//   req_unsigned           load zero-extend (1) / sign-extend (0)
//   req_addr/req_wdata     byte address, store data (low-order bits)
//   resp_valid/resp_rdata/resp_err   completion pulse, load result, error flag
//   MemRead/MemWrite       memory read enable, write strobe
//   addr/write_data        word-aligned memory address, write data
//   read_data              combinational memory read data
//
// state  | meaning
// IDLE   | waiting for a request
// RD     | MemRead high, read_data captured at end
// WSETUP | addr/write_data driven, MemWrite low
// WPULSE | MemWrite high
// WHOLD  | MemWrite low, addr/write_data held
// DONE   | resp_valid pulse

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_DONE
    } state_t;

    state_t state, state_next;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        range_err;
    logic        req_err;

    logic        mem_read_d, mem_write_d, resp_valid_d, resp_err_d;
    logic [31:0] addr_d, write_data_d, resp_rdata_d;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

`ifdef LSU_RANGE_CHECK_EN
    assign range_err = |req_addr[31:9];
`else
    assign range_err = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || range_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                           state_next = S_DONE;
                    else if (req_write && req_size == 2'b10) state_next = S_WSETUP;
                    else                                   state_next = S_RD;
                end
            end
            S_RD:     state_next = lat_write ? S_WSETUP : S_DONE;
            S_WSETUP: state_next = S_WPULSE;
            S_WPULSE: state_next = S_WHOLD;
            S_WHOLD:  state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Next values for the registered memory-side and response outputs.
    always_comb begin
        mem_read_d   = (state_next == S_RD);
        mem_write_d  = (state_next == S_WPULSE);
        resp_valid_d = (state_next == S_DONE);
        resp_err_d   = (state == S_IDLE) && accept && req_err;
        resp_rdata_d = 32'h0;
        addr_d       = addr;
        write_data_d = write_data;
        if (state == S_IDLE && accept && !req_err) begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_write && req_size == 2'b10) write_data_d = req_wdata;
        end
        if (state == S_RD) begin
            if (lat_write) write_data_d = store_merge(read_data, lat_size, lat_lane, lat_wdata);
            else           resp_rdata_d = load_extract(read_data, lat_size, lat_lane, lat_unsigned);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            addr         <= 32'h0;
            write_data   <= 32'h0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
            lat_wdata    <= 32'h0;
        end else begin
            MemRead    <= mem_read_d;
            MemWrite   <= mem_write_d;
            addr       <= addr_d;
            write_data <= write_data_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_lane     <= req_addr[1:0];
                lat_wdata    <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] addr, write_data, read_data;

    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .write_data(write_data), .read_data(read_data)
    );

    // Data memory: combinational read, write on rising edge of MemWrite.
    assign read_data = MemRead ? mem[addr[8:2]] : 32'h0;
    always @(posedge MemWrite) mem[addr[8:2]] = write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs();
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // Issues one request and checks it against a reference computed from the
    // access rules with plain arithmetic on ref_mem.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] got_rdata, output logic got_err);
        logic        err;
        int          exp_lat, lat, idx, sh, rd_cyc, wr_cyc, both;
        logic [31:0] word, exp_rd, exp_word, mask;
        logic [31:0] addr_s [8];
        logic [31:0] wdat_s [8];
        logic [7:0]  mw_s;

        idx  = int'(a[8:2]);
        word = ref_mem[idx];
        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
        err  = err || (a[31:9] != 0);
`endif
        exp_rd   = 32'h0;
        exp_word = word;
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        if (!err && !wr) begin
            exp_rd = (word >> sh) & mask;
            if (!uns && sz == 2'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
            if (!uns && sz == 2'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
        end
        if (!err && wr) exp_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
        if (err)                    exp_lat = 1;
        else if (!wr)               exp_lat = 2;
        else if (sz == 2'd2)        exp_lat = 4;
        else                        exp_lat = 5;

        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        junk_inputs();

        lat = 0; rd_cyc = 0; wr_cyc = 0; both = 0; mw_s = 8'h0;
        got_rdata = 32'hX; got_err = 1'bX;
        for (int c = 1; c <= 20; c++) begin
            if (c < 8) begin
                addr_s[c] = addr;
                wdat_s[c] = write_data;
                mw_s[c]   = MemWrite;
            end
            if (MemRead) rd_cyc++;
            if (MemWrite) wr_cyc++;
            if (MemRead && MemWrite) both++;
            if (resp_valid) begin
                lat = c;
                got_rdata = resp_rdata;
                got_err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'b0, got_err}, {31'b0, err});
        chk("resp_rdata", got_rdata, exp_rd);
        chk("memread_cycles", rd_cyc, (!err && (!wr || sz != 2'd2)) ? 1 : 0);
        chk("memwrite_cycles", wr_cyc, (!err && wr) ? 1 : 0);
        chk("rd_wr_overlap", both, 0);
        if (!err && wr && lat == exp_lat) begin
            for (int c = lat - 3; c <= lat - 1; c++) begin
                chk("wr_addr_stable", addr_s[c], {a[31:2], 2'b00});
                chk("wr_data_stable", wdat_s[c], exp_word);
            end
            chk("pulse_position", {31'b0, mw_s[lat-2]}, 32'd1);
        end
        @(posedge clk);
        #1;
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
        chk("ready_after", {31'b0, req_ready}, 32'd1);
        if (!err && wr) ref_mem[idx] = exp_word;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          mism;
        logic        seen;

        for (int i = 0; i < 128; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        req_valid = 1'b0;
        junk_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_resp", {29'b0, resp_valid, resp_err, req_ready}, 32'd1);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed plan.
        run_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er);
        run_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er);
        chk("tp1_load", rd, 32'hDEADBEEF);
        run_req(1, 2'd2, 0, 32'h20, 32'h11223344, rd, er);
        run_req(1, 2'd0, 0, 32'h23, 32'h000000A5, rd, er);
        run_req(0, 2'd2, 0, 32'h20, 32'h0, rd, er);
        chk("tp2_word", rd, 32'hA5223344);
        run_req(0, 2'd0, 0, 32'h23, 32'h0, rd, er);
        chk("tp2_byte_s", rd, 32'hFFFFFFA5);
        run_req(0, 2'd0, 1, 32'h23, 32'h0, rd, er);
        chk("tp2_byte_u", rd, 32'h000000A5);
        run_req(1, 2'd2, 0, 32'h30, 32'h80011234, rd, er);
        run_req(0, 2'd1, 0, 32'h32, 32'h0, rd, er);
        chk("tp3_half_s", rd, 32'hFFFF8001);
        run_req(0, 2'd1, 1, 32'h30, 32'h0, rd, er);
        chk("tp3_half_u", rd, 32'h00001234);
        run_req(0, 2'd2, 0, 32'h06, 32'h0, rd, er);
        chk("tp4_word_misal", {31'b0, er}, 32'd1);
        run_req(1, 2'd1, 0, 32'h05, 32'hFFFF, rd, er);
        chk("tp4_half_misal", {31'b0, er}, 32'd1);
        run_req(0, 2'd2, 0, 32'h200, 32'h0, rd, er);
`ifdef LSU_RANGE_CHECK_EN
        chk("tp6_range_err", {31'b0, er}, 32'd1);
`else
        chk("tp6_alias", rd, ref_mem[0]);
`endif

        // Reset during WPULSE of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (MemWrite) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("tp5_pulse_seen", {31'b0, seen}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tp5_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("tp5_addr", addr, 32'd0);
        chk("tp5_wdata", write_data, 32'd0);
        chk("tp5_resp", {31'b0, resp_valid}, 32'd0);
        ref_mem[16] = 32'hCAFEF00D;
        chk("tp5_written", mem[16], 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("tp5_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("tp5_ready", {31'b0, req_ready}, 32'd1);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) ra = ra | ($urandom & 32'hFFFF_FE00);
            run_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, rd, er);
        end

        mism = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
